// File: rtl/afc_seq_pkg.sv
// Shared types and constants for the AFC calibration sequencer.
// Build option: AFC_RETRY_EN (see afc_cal_sequencer).
package afc_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W = 2;
    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] CODE_MID = 6'd32;

    typedef enum logic [3:0] {
        IDLE,
        SELECT,
        START,
        WAIT_HI,
        WAIT_LO,
        CAPTURE,
        FAIL,
        NEXT,
        DONE
    } seqState_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] ch;
    } chPick_t;

    // Lowest enabled channel above cur; fromStart considers every channel.
    function automatic chPick_t pickNextCh(input logic [NUM_CH-1:0] mask,
                                           input logic [CH_W-1:0]   cur,
                                           input logic              fromStart);
        chPick_t pick;
        pick.found = 1'b0;
        pick.ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (fromStart || (i > int'(cur)))) begin
                pick.found = 1'b1;
                pick.ch = CH_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/afc_sync2.sv
// Two-flop synchronizer bringing the AFC core's busy flag into CLK40.
module afc_sync2 (
    input  logic CLK40,
    input  logic reset,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    always_ff @(posedge CLK40) begin
        if (reset) begin
            meta <= 1'b0;
            syncOut <= 1'b0;
        end else begin
            meta <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/afc_cal_sequencer.sv
// Walks the enabled PLL channels, runs one AFC calibration each and stores the codes.
// Build option: define AFC_RETRY_EN to retry a timed-out channel up to MAX_RETRY times.
module afc_cal_sequencer
    import afc_seq_pkg::*;
#(
    parameter int SETTLE_CYC   = 8,
    parameter int START_LEN    = 4,
    parameter int BUSY_RISE_TO = 64,
    parameter int CAL_TO       = 65535
`ifdef AFC_RETRY_EN
    ,
    parameter int MAX_RETRY    = 1
`endif
) (
    input  logic              CLK40,
    input  logic              reset,
    input  logic              seqStart,
    input  logic [NUM_CH-1:0] chEnMask,
    input  logic              calSourceCfg,
    input  logic              AFCbusy,
    input  logic [CODE_W-1:0] calControlCode,
    output logic              AFCstart,
    output logic [CH_W-1:0]   calChSel,
    output logic              calSource,
    output logic              overridecontrol,
    output logic [CODE_W-1:0] overridecontrol_val1,
    output logic [CODE_W-1:0] overridecontrol_val2,
    output logic [CODE_W-1:0] overridecontrol_val3,
    output logic [CODE_W-1:0] overridecontrol_val4,
    output logic              seqBusy,
    output logic              seqDone,
    output logic [NUM_CH-1:0] chDone,
    output logic [NUM_CH-1:0] chErr
);

    localparam int LONG_A = (SETTLE_CYC > START_LEN) ? SETTLE_CYC : START_LEN;
    localparam int LONG_B = (BUSY_RISE_TO > CAL_TO) ? BUSY_RISE_TO : CAL_TO;
    localparam int LONGEST = (LONG_A > LONG_B) ? LONG_A : LONG_B;
    localparam int CNT_W = $clog2(LONGEST + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
    // The busy-rise window is measured from AFCstart rise, so START time is deducted.
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(BUSY_RISE_TO - START_LEN - 1);
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_TO - 1);

    seqState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] maskQ;
    logic              fromStart;
    logic [CODE_W-1:0] codeQ [NUM_CH];
    logic              busyS;
    logic              failFinal;
    chPick_t           pick;

    afc_sync2 uBusySync (
        .CLK40   (CLK40),
        .reset   (reset),
        .asyncIn (AFCbusy),
        .syncOut (busyS)
    );

`ifdef AFC_RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retryCnt;
    assign failFinal = (retryCnt >= RTY_W'(MAX_RETRY));
`else
    assign failFinal = 1'b1;
`endif

    assign pick = pickNextCh(maskQ, calChSel, fromStart);

    assign overridecontrol_val1 = codeQ[0];
    assign overridecontrol_val2 = codeQ[1];
    assign overridecontrol_val3 = codeQ[2];
    assign overridecontrol_val4 = codeQ[3];

    always_comb begin
        stateNext = state;
        AFCstart = 1'b0;
        seqDone = 1'b0;
        seqBusy = (state != IDLE) && (state != DONE);
        unique case (state)
            IDLE:    if (seqStart) stateNext = NEXT;
            SELECT:  if (cnt >= SETTLE_LAST) stateNext = START;
            START: begin
                AFCstart = 1'b1;
                if (cnt >= START_LAST) stateNext = WAIT_HI;
            end
            WAIT_HI: begin
                if (busyS) stateNext = WAIT_LO;
                else if (cnt >= RISE_LAST) stateNext = FAIL;
            end
            WAIT_LO: begin
                if (!busyS) stateNext = CAPTURE;
                else if (cnt >= CAL_LAST) stateNext = FAIL;
            end
            CAPTURE: stateNext = NEXT;
            FAIL:    stateNext = failFinal ? NEXT : SELECT;
            NEXT:    stateNext = pick.found ? SELECT : DONE;
            DONE: begin
                seqDone = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            maskQ <= '0;
            fromStart <= 1'b0;
            calChSel <= '0;
            calSource <= 1'b0;
            overridecontrol <= 1'b1;
            chDone <= '0;
            chErr <= '0;
            for (int i = 0; i < NUM_CH; i++) codeQ[i] <= CODE_MID;
`ifdef AFC_RETRY_EN
            retryCnt <= '0;
`endif
        end else begin
            state <= stateNext;
            // One timer serves every state; it restarts on each transition and saturates.
            if (stateNext != state) cnt <= '0;
            else if (cnt != '1) cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (seqStart) begin
                        maskQ <= chEnMask;
                        calSource <= calSourceCfg;
                        chDone <= '0;
                        chErr <= '0;
                        fromStart <= 1'b1;
                    end
                end
                CAPTURE: begin
                    codeQ[calChSel] <= calControlCode;
                    chDone[calChSel] <= 1'b1;
                end
                FAIL: begin
                    if (failFinal) chErr[calChSel] <= 1'b1;
`ifdef AFC_RETRY_EN
                    else retryCnt <= retryCnt + 1'b1;
`endif
                end
                NEXT: begin
                    fromStart <= 1'b0;
`ifdef AFC_RETRY_EN
                    retryCnt <= '0;
`endif
                    // Override is released only while a channel is actually being calibrated.
                    if (pick.found) begin
                        calChSel <= pick.ch;
                        overridecontrol <= 1'b0;
                    end else begin
                        overridecontrol <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
